// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
// sram_arbiter_if: request/acknowledge bundle between the two SRAM clients
// and the arbiter.
//   port A (video, read-only): a_req, a_addr -> a_rdata, a_ack
//   port B (CPU, read/write) : b_req, b_we, b_addr, b_wdata -> b_rdata, b_ack
//   busy                     : arbiter is in the middle of an access
// Modports:
//   master : the requester side (video/CPU logic)
//   slave  : the arbiter side
interface sram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic          a_ack;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_ack;
    logic          busy;

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        input  a_rdata, a_ack, b_rdata, b_ack, busy
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
        output a_rdata, a_ack, b_rdata, b_ack, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter: two-port controller for an asynchronous SRAM (1Kx8 by default).
// Port A (video fetch) is read-only, port B (CPU) reads and writes. Each
// access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE, so the
// address is stable a full cycle before the strobe and the address/write data
// stay valid a full cycle after it. When both ports request together the
// grant alternates (round-robin).
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : request/ack bundle for ports A and B, plus busy
//   sram_a       : registered SRAM address
//   sram_d       : SRAM data, driven only during a port B write
//   sram_ce_n/oe_n/we_n : registered active-low SRAM strobes
module sram_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus,
    output logic [AW-1:0]   sram_a,
    inout  wire  [DW-1:0]   sram_d,
    output logic            sram_ce_n,
    output logic            sram_oe_n,
    output logic            sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          grant_b_r;   // 1: current access belongs to port B
    logic          last_b_r;    // 1: port B won the most recent grant
    logic          we_r;
    logic [DW-1:0] wdata_r;
    logic [AW-1:0] sram_a_r;
    logic          ce_n_r, oe_n_r, we_n_r, drive_r;
    logic          a_ack_r, b_ack_r;
    logic [DW-1:0] a_rdata_r, b_rdata_r;

    logic          grant_now_s, pick_b_s, we_s;
    logic          ce_n_s, oe_n_s, we_n_s, drive_s;
    logic          ack_s, rd_cap_s;

    // Next-state, arbitration and next strobe values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        // B only wins a tie if A had the previous grant.
        pick_b_s    = bus.b_req && (!bus.a_req || !last_b_r);
        grant_now_s = (state_r == S_IDLE) && (bus.a_req || bus.b_req);
        case (state_r)
            S_IDLE: begin
                if (grant_now_s) begin
                    state_s = S_SETUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                state_s = S_ACCESS;
                cnt_s   = {CW{1'b0}};
            end
            S_ACCESS: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = S_HOLD;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = S_ACCESS;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            S_HOLD: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
        // Direction of the access being entered (latched value once granted).
        we_s     = grant_now_s ? (pick_b_s && bus.b_we) : we_r;
        // Strobes are registered, so they are derived from the next state.
        ce_n_s   = (state_s == S_IDLE);
        oe_n_s   = !((state_s == S_ACCESS) && !we_s);
        we_n_s   = !((state_s == S_ACCESS) && we_s);
        // Write data covers SETUP through HOLD for setup/hold margin.
        drive_s  = (state_s != S_IDLE) && we_s;
        ack_s    = (state_r == S_ACCESS) && (state_s == S_HOLD);
        // Read data is taken at the end of the last oe_n-low cycle.
        rd_cap_s = (state_r == S_ACCESS) && (cnt_r == CNT_LAST) && !we_r;
    end

    // State register, counter and registered SRAM strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CW{1'b0}};
            ce_n_r    <= 1'b1;
            oe_n_r    <= 1'b1;
            we_n_r    <= 1'b1;
            drive_r   <= 1'b0;
            a_ack_r   <= 1'b0;
            b_ack_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            ce_n_r    <= ce_n_s;
            oe_n_r    <= oe_n_s;
            we_n_r    <= we_n_s;
            drive_r   <= drive_s;
            a_ack_r   <= ack_s && !grant_b_r;
            b_ack_r   <= ack_s && grant_b_r;
        end
    end

    // Grant bookkeeping: request fields are frozen here until the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_b_r <= 1'b0;
            last_b_r  <= 1'b1;
            we_r      <= 1'b0;
            wdata_r   <= {DW{1'b0}};
            sram_a_r  <= {AW{1'b0}};
        end else if (grant_now_s) begin
            grant_b_r <= pick_b_s;
            last_b_r  <= pick_b_s;
            we_r      <= pick_b_s && bus.b_we;
            wdata_r   <= bus.b_wdata;
            sram_a_r  <= pick_b_s ? bus.b_addr : bus.a_addr;
        end
    end

    // Read data capture into the granted port; the other port keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_r <= {DW{1'b0}};
            b_rdata_r <= {DW{1'b0}};
        end else if (rd_cap_s) begin
            if (grant_b_r) begin
                b_rdata_r <= sram_d;
            end else begin
                a_rdata_r <= sram_d;
            end
        end
    end

    assign sram_a      = sram_a_r;
    assign sram_ce_n   = ce_n_r;
    assign sram_oe_n   = oe_n_r;
    assign sram_we_n   = we_n_r;
    assign sram_d      = drive_r ? wdata_r : {DW{1'bz}};
    assign bus.a_ack   = a_ack_r;
    assign bus.b_ack   = b_ack_r;
    assign bus.a_rdata = a_rdata_r;
    assign bus.b_rdata = b_rdata_r;
    assign bus.busy    = (state_r != S_IDLE);

endmodule
